// File: rtl/n101_uarttx.sv
// n101_uarttx: FIFO-buffered UART transmitter, 8N1/8N2 frames, bit period io_div+1 clocks
module n101_uarttx #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_en,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [7:0]  io_in_bits,
  output logic        io_out,
  input  logic [15:0] io_div,
  input  logic        io_nstop,
  output logic        io_busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t r_state, w_state_nx;
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic [10:0] r_shift, w_shift_nx;
  logic [3:0] r_bitcnt, w_bitcnt_nx, w_cnt_dec;
  logic [15:0] r_pre, w_pre_nx;
  logic r_out, w_out_nx;
  logic w_push, w_empty, w_bound, w_done, w_load;
  assign io_in_ready = r_count != (AW+1)'(DEPTH);
  assign w_push = io_in_valid & io_in_ready;
  assign w_empty = r_count == '0;
  assign w_bound = r_state == SHIFT && r_pre == '0;
  assign w_cnt_dec = r_bitcnt - 4'd1;
  assign w_done = w_bound && w_cnt_dec == '0;
  // a finishing frame may hand straight over to the next one with no idle gap
  assign w_load = io_en && !w_empty && (r_state == IDLE || w_done);
  assign io_out = r_out;
  assign io_busy = r_state != IDLE || !w_empty;
  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_bitcnt_nx = r_bitcnt;
    w_pre_nx = r_pre;
    w_out_nx = r_out;
    if (w_load) begin
      w_state_nx = SHIFT;
      w_shift_nx = {2'b11, r_mem[r_rptr], 1'b0};
      w_bitcnt_nx = io_nstop ? 4'd11 : 4'd10;
      w_pre_nx = io_div;
      w_out_nx = 1'b0;
    end else if (w_done) begin
      w_state_nx = IDLE;
      w_out_nx = 1'b1;
    end else if (w_bound) begin
      w_bitcnt_nx = w_cnt_dec;
      w_shift_nx = {1'b1, r_shift[10:1]};
      w_out_nx = r_shift[1];
      w_pre_nx = io_div;
    end else if (r_state == SHIFT) begin
      w_pre_nx = r_pre - 16'd1;
    end
  end
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= io_in_bits;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_shift <= '1;
      r_bitcnt <= '0;
      r_pre <= '0;
      r_out <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_wptr <= r_wptr + AW'(w_push);
      r_rptr <= r_rptr + AW'(w_load);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_load);
      r_shift <= w_shift_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_pre <= w_pre_nx;
      r_out <= w_out_nx;
    end
  end
endmodule

// File: tb/tb_n101_uarttx.sv
// tb_n101_uarttx: directed checks of framing, FIFO, enable gating and reset of n101_uarttx
module tb_n101_uarttx;
  logic clock = 0, reset = 1, io_en = 0, io_in_valid = 0, io_nstop = 0;
  logic [7:0] io_in_bits = '0;
  logic [15:0] io_div = 16'd3;
  logic io_in_ready, io_out, io_busy;
  int checks = 0, errors = 0;
  n101_uarttx dut (
    .clock(clock), .reset(reset), .io_en(io_en), .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready), .io_in_bits(io_in_bits), .io_out(io_out),
    .io_div(io_div), .io_nstop(io_nstop), .io_busy(io_busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] d);
    io_in_valid = 1;
    io_in_bits = d;
    @(negedge clock);
    io_in_valid = 0;
  endtask
  task automatic frame(input string tag, input logic [7:0] d, input int ns, input bit contig, input int drop_bit);
    int k;
    logic [10:0] fr;
    fr = {2'b11, d, 1'b0};
    if (contig) chk({tag, "_gap"}, io_out, 0);
    else begin
      k = 0;
      while (io_out !== 1'b0 && k < 2000) begin
        @(negedge clock);
        k++;
      end
      if (k >= 2000) begin
        chk({tag, "_timeout"}, io_out, 0);
        return;
      end
    end
    for (int b = 0; b < 10 + ns; b++)
      for (int c = 0; c <= int'(io_div); c++) begin
        if (b == drop_bit && c == 0) io_en = 0;
        chk(tag, io_out, fr[b]);
        @(negedge clock);
      end
  endtask
  initial begin
    repeat (3) @(negedge clock);
    reset = 0;
    chk("rst_ready", io_in_ready, 1);
    chk("rst_out", io_out, 1);
    chk("rst_busy", io_busy, 0);
    // T1: single 8N1 frame, 4-clock bits
    io_en = 1;
    push(8'hA5);
    chk("t1_lat", io_out, 1);
    chk("t1_busy", io_busy, 1);
    frame("t1", 8'hA5, 0, 0, -1);
    chk("t1_busy_end", io_busy, 0);
    chk("t1_out_end", io_out, 1);
    // T2: fill while disabled, then contiguous frames in order
    io_en = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_ready", io_in_ready, i < 4);
      io_in_valid = 1;
      io_in_bits = 8'(8'h11 * (i + 1));
      @(negedge clock);
    end
    io_in_valid = 0;
    chk("t2_full", io_in_ready, 0);
    chk("t2_busy", io_busy, 1);
    repeat (5) begin
      chk("t2_idle_out", io_out, 1);
      @(negedge clock);
    end
    io_div = 16'd1;
    io_en = 1;
    frame("t2_0", 8'h11, 0, 0, -1);
    frame("t2_1", 8'h22, 0, 1, -1);
    frame("t2_2", 8'h33, 0, 1, -1);
    frame("t2_3", 8'h44, 0, 1, -1);
    chk("t2_busy_end", io_busy, 0);
    chk("t2_out_end", io_out, 1);
    // T3: two stop bits, 2-clock bits
    io_nstop = 1;
    push(8'hFF);
    frame("t3", 8'hFF, 1, 0, -1);
    chk("t3_busy_end", io_busy, 0);
    io_nstop = 0;
    // T4: enable dropped in the third data bit
    io_div = 16'd3;
    io_en = 0;
    push(8'h3C);
    push(8'hC3);
    push(8'h5A);
    io_en = 1;
    frame("t4a", 8'h3C, 0, 0, 3);
    repeat (12) begin
      chk("t4_hold_out", io_out, 1);
      chk("t4_hold_busy", io_busy, 1);
      @(negedge clock);
    end
    io_en = 1;
    frame("t4b", 8'hC3, 0, 0, -1);
    frame("t4c", 8'h5A, 0, 1, -1);
    chk("t4_busy_end", io_busy, 0);
    // T5: reset mid-frame with a full FIFO
    io_en = 0;
    for (int i = 0; i < 4; i++) push(8'(8'h70 + i));
    io_en = 1;
    repeat (3) @(negedge clock);
    push(8'h77);
    chk("t5_full", io_in_ready, 0);
    chk("t5_mid", io_out, 0);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("t5_out", io_out, 1);
    chk("t5_ready", io_in_ready, 1);
    chk("t5_busy", io_busy, 0);
    repeat (6) begin
      chk("t5_quiet", io_out, 1);
      @(negedge clock);
    end
    // T6: receiver-matched divisor, four bytes back to back
    io_en = 0;
    io_div = 16'h001F;
    push(8'h00);
    push(8'h55);
    push(8'hAA);
    push(8'hFF);
    io_en = 1;
    frame("t6_0", 8'h00, 0, 0, -1);
    frame("t6_1", 8'h55, 0, 1, -1);
    frame("t6_2", 8'hAA, 0, 1, -1);
    frame("t6_3", 8'hFF, 0, 1, -1);
    chk("t6_busy_end", io_busy, 0);
    // one-clock bits
    io_div = 16'd0;
    push(8'h81);
    frame("t7", 8'h81, 0, 0, -1);
    chk("t7_busy_end", io_busy, 0);
    chk("t7_out_end", io_out, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
